// File: rtl/x_tdc_edge_stats.sv
// ---------------------------------------------------------------------------
// x_tdc_edge_stats
//
// Edge-position statistics for a tapped-delay-line TDC. On a start request the
// block captures 2^p_log2_n consecutive tap snapshots, locates the first
// transition in each one and reports the minimum, maximum and truncated mean
// edge position, plus how many snapshots contained no transition at all.
//
// Parameters
//   p_length  : delay-line tap count (power of 2, >= 8)
//   p_log2_n  : log2 of snapshots per measurement (1..12)
//
// Ports
//   i_clk     : clock, all state on the rising edge
//   i_nrst    : asynchronous active-low reset
//   i_data    : raw tap snapshot, valid every cycle
//   i_start   : single-cycle measurement request (honoured only when idle)
//   i_ready   : downstream accepts the result (honoured only when o_valid)
//   o_busy    : measurement in progress or result waiting
//   o_valid   : result available, outputs held until i_ready
//   o_min     : smallest edge position seen
//   o_max     : largest edge position seen
//   o_avg     : sum of positions >> p_log2_n
//   o_nedge   : number of snapshots with no edge (position == p_length)
//
// Build option
//   X_TDC_BUBBLE_FILTER_EN : when defined, a 3-tap per-bit majority filter
//                            cleans bubbles before encoding; latency unchanged.
// ---------------------------------------------------------------------------
module x_tdc_edge_stats #(
    parameter int p_length = 256,
    parameter int p_log2_n = 4
) (
    input  logic                      i_clk,
    input  logic                      i_nrst,
    input  logic [p_length-1:0]       i_data,
    input  logic                      i_start,
    input  logic                      i_ready,
    output logic                      o_busy,
    output logic                      o_valid,
    output logic [$clog2(p_length):0] o_min,
    output logic [$clog2(p_length):0] o_max,
    output logic [$clog2(p_length):0] o_avg,
    output logic [p_log2_n:0]         o_nedge
);

    localparam int LW = $clog2(p_length) + 1;   // position width, holds p_length
    localparam int SW = LW + p_log2_n;          // sum width, cannot overflow
    localparam int NW = p_log2_n + 1;           // no-edge counter width
    localparam int CW = p_log2_n;               // sample / drain counter width

    typedef enum logic [1:0] {IDLE, ACQ, DRAIN, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;

    logic [p_length-1:0] data_p0;
    logic                vld_p0;
    logic [LW-1:0]       pos_p1;
    logic                vld_p1;
    logic [LW-1:0]       min_p2;
    logic [LW-1:0]       max_p2;
    logic [SW-1:0]       sum_p2;
    logic [NW-1:0]       nedge_p2;

`ifdef X_TDC_BUBBLE_FILTER_EN
    // Majority of each bit with its two neighbours. The end bits see their own
    // value replicated in place of the missing neighbour, so they pass through.
    function automatic logic [p_length-1:0] bubble_filter(input logic [p_length-1:0] d);
        logic [p_length-1:0] f;
        f[0]          = d[0];
        f[p_length-1] = d[p_length-1];
        for (int i = 1; i < p_length - 1; i++) begin
            f[i] = (d[i-1] & d[i]) | (d[i] & d[i+1]) | (d[i-1] & d[i+1]);
        end
        return f;
    endfunction
`endif

    // Lowest index whose bit differs from the next one up; p_length if none.
    // Scanning downwards lets the lowest match overwrite any higher one.
    function automatic logic [LW-1:0] edge_pos(input logic [p_length-1:0] d);
        logic [LW-1:0] pos;
        pos = LW'(p_length);
        for (int i = p_length - 2; i >= 0; i--) begin
            if (d[i] != d[i+1]) pos = LW'(i);
        end
        return pos;
    endfunction

    // Truncating mean: drop the p_log2_n fractional bits of the sum.
    function automatic logic [LW-1:0] avg_trunc(input logic [SW-1:0] s);
        logic [SW-1:0] q;
        q = s >> p_log2_n;
        return q[LW-1:0];
    endfunction

    // Control: a sample is captured on every ACQ cycle, then two DRAIN cycles
    // let the last one reach the accumulators before the result is declared.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state   <= IDLE;
            cnt     <= '0;
            o_busy  <= 1'b0;
            o_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state  <= ACQ;
                        cnt    <= '0;
                        o_busy <= 1'b1;
                    end
                end
                ACQ: begin
                    cnt <= cnt + CW'(1);
                    if (&cnt) begin
                        state <= DRAIN;
                        cnt   <= '0;
                    end
                end
                DRAIN: begin
                    cnt <= cnt + CW'(1);
                    if (cnt[0]) begin
                        state   <= DONE;
                        o_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state   <= IDLE;
                        o_busy  <= 1'b0;
                        o_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage 1: register the raw snapshot
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            data_p0 <= '0;
            vld_p0  <= 1'b0;
        end else begin
            data_p0 <= i_data;
            vld_p0  <= (state == ACQ);
        end
    end

    // Stage 2: (optional filter) and encode the edge position
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            pos_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
`ifdef X_TDC_BUBBLE_FILTER_EN
            pos_p1 <= edge_pos(bubble_filter(data_p0));
`else
            pos_p1 <= edge_pos(data_p0);
`endif
            vld_p1 <= vld_p0;
        end
    end

    // Stage 3: accumulate statistics; cleared as a new measurement starts
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            min_p2   <= '0;
            max_p2   <= '0;
            sum_p2   <= '0;
            nedge_p2 <= '0;
        end else if (state == IDLE && i_start) begin
            min_p2   <= LW'(p_length);
            max_p2   <= '0;
            sum_p2   <= '0;
            nedge_p2 <= '0;
        end else if (vld_p1) begin
            if (pos_p1 < min_p2) min_p2 <= pos_p1;
            if (pos_p1 > max_p2) max_p2 <= pos_p1;
            sum_p2 <= sum_p2 + SW'(pos_p1);
            if (pos_p1 == LW'(p_length)) nedge_p2 <= nedge_p2 + NW'(1);
        end
    end

    assign o_min   = min_p2;
    assign o_max   = max_p2;
    assign o_avg   = avg_trunc(sum_p2);
    assign o_nedge = nedge_p2;

endmodule
